// File: rtl/controle_varredura_pkg.sv
// Shared definitions for the scan controller: state codes (also exported on
// db_estado), counter control polarities and the Moore output decode.
package controle_varredura_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTOU = 4'b1010,
    FIM_ERROU   = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } estado_t;

  // Active levels of the 74163 synchronous clear/load inputs
  localparam logic CLR_ATIVO = 1'b0;
  localparam logic LD_ATIVO  = 1'b0;

  typedef struct packed {
    logic clr_n;
    logic ld_n;
    logic ent;
    logic enp;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
    logic zera_timer;
    logic conta_timer;
  } saidas_t;

  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s       = '0;
    s.clr_n = ~CLR_ATIVO;
    s.ld_n  = ~LD_ATIVO;
    case (e)
      PREPARACAO: begin
        s.ld_n       = LD_ATIVO;
        s.zera_r     = 1'b1;
        s.zera_timer = 1'b1;
      end
      ESPERA:   s.conta_timer = 1'b1;
      REGISTRA: s.registra_r  = 1'b1;
      PROXIMO: begin
        s.ent        = 1'b1;
        s.enp        = 1'b1;
        s.zera_timer = 1'b1;
      end
      FIM_ACERTOU: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.errou   = 1'b1;
        s.timeout = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/controle_varredura_timer.sv
// Inactivity timer for the espera state.
// Ports: clock, reset (async, active-high), zera (sync clear), conta (count
// enable), fim (high while the count equals TIMEOUT_CICLOS-1).
module timer_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = $clog2(TIMEOUT_CICLOS);
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      contagem <= '0;
    else if (zera)  contagem <= '0;
    else if (conta) contagem <= contagem + W'(1);
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/controle_varredura.sv
// Moore controller sequencing the 74163 address counter through a stored
// sequence check: register move, compare, advance; stops on mismatch, on the
// last address (fimC) or on inactivity timeout.
// Inputs : clock, reset (async, active-high), iniciar, jogada, igual, fimC.
// Outputs: counter controls (clr_n, ld_n, ent, enp, carga_valor), move
//          register controls (zeraR, registraR), verdict flags (pronto,
//          acertou, errou, timeout) and db_estado (current state code).
module controle_varredura
  import controle_varredura_pkg::*;
#(
  parameter logic [3:0]  ENDERECO_INICIAL = 4'd0,
  parameter int unsigned TIMEOUT_CICLOS   = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       clr_n,
  output logic       ld_n,
  output logic       ent,
  output logic       enp,
  output logic [3:0] carga_valor,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado, proximo_estado;
  saidas_t saidas;
  logic    fim_timer;

  timer_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (saidas.zera_timer),
    .conta (saidas.conta_timer),
    .fim   (fim_timer)
  );

  always_comb begin
    proximo_estado = INICIAL;
    case (estado)
      INICIAL:    proximo_estado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: proximo_estado = ESPERA;
      ESPERA: begin
        // a move arriving on the timeout cycle still wins
        if (jogada)         proximo_estado = REGISTRA;
        else if (fim_timer) proximo_estado = FIM_TIMEOUT;
        else                proximo_estado = ESPERA;
      end
      REGISTRA: proximo_estado = COMPARACAO;
      COMPARACAO: begin
        // ent is low here, so fimC must come from the Q==15 decode upstream
        if (!igual)    proximo_estado = FIM_ERROU;
        else if (fimC) proximo_estado = FIM_ACERTOU;
        else           proximo_estado = PROXIMO;
      end
      PROXIMO: proximo_estado = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
        proximo_estado = iniciar ? PREPARACAO : estado;
      default: proximo_estado = INICIAL;
    endcase
  end

  // Outputs are registered from the next-state decode so they always equal
  // the decode of the current state without a combinational output path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
      saidas <= decodifica(INICIAL);
    end else begin
      estado <= proximo_estado;
      saidas <= decodifica(proximo_estado);
    end
  end

  assign clr_n       = saidas.clr_n;
  assign ld_n        = saidas.ld_n;
  assign ent         = saidas.ent;
  assign enp         = saidas.enp;
  assign zeraR       = saidas.zera_r;
  assign registraR   = saidas.registra_r;
  assign pronto      = saidas.pronto;
  assign acertou     = saidas.acertou;
  assign errou       = saidas.errou;
  assign timeout     = saidas.timeout;
  assign carga_valor = ENDERECO_INICIAL;
  assign db_estado   = estado;

endmodule

// File: doc/controle_varredura.md
Name: controle_varredura

Overview:
Moore FSM that sequences the 4-bit 74163-style address counter through an acerto/erro check of a stored sequence.
- On each player move (jogada), it registers the move, compares it, then advances the counter.
- It stops on a mismatch, on the last address (counter rco), or when an internal inactivity timer expires.
- It sits in the unidade de controle of the experiment top level, beside the fluxo de dados that holds the counter, memory, register and comparator.

Parameters:
ENDERECO_INICIAL, 4'd0, value driven on carga_valor and loaded into the counter at start.
TIMEOUT_CICLOS, 5000, clock cycles allowed in espera before a timeout; legal range 2..2^20.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces state inicial
iniciar  in  1  start request, level sampled on clock
jogada  in  1  one-cycle pulse: move available on datapath
igual  in  1  comparator result, memory == registered move
fimC  in  1  counter rco (ent && Q==15)
clr_n  out  1  counter synchronous clear, active-low
ld_n  out  1  counter synchronous load, active-low
ent  out  1  counter enable T
enp  out  1  counter enable P
carga_valor  out  4  counter D input (= ENDERECO_INICIAL)
zeraR  out  1  clear move register
registraR  out  1  load move register
pronto  out  1  sequence finished (any outcome)
acertou  out  1  finished, all moves correct
errou  out  1  finished by mismatch or timeout
timeout  out  1  finished by timeout
db_estado  out  4  current state code, debug

Behaviour:
- Outputs are decoded from state only (Moore). Defaults: clr_n=1, ld_n=1, ent=enp=0, zeraR=registraR=0, all flags 0. carga_valor is constant.
- State codes (db_estado):
  - inicial 0000
  - preparacao 0001
  - espera 0010
  - registra 0100
  - comparacao 0101
  - proximo 0110
  - fim_acertou 1010
  - fim_errou 1110
  - fim_timeout 1101
- Reset (async, any time, including mid-sequence): state=inicial, timer=0, outputs at defaults, db_estado=0000. Release is sampled at the next rising edge.
- inicial: iniciar=1 -> preparacao, else stay.
- preparacao: ld_n=0, zeraR=1, timer cleared; -> espera. The counter holds ENDERECO_INICIAL one edge later.
- espera:
  - Timer increments each cycle.
  - jogada=1 -> registra (has priority over timeout in the same cycle).
  - Else if timer==TIMEOUT_CICLOS-1 -> fim_timeout.
  - Else stay.
- registra: registraR=1; -> comparacao.
- comparacao:
  - igual=0 -> fim_errou.
  - Else fimC=1 -> fim_acertou.
  - Else -> proximo.
  - While in comparacao ent=0, so the counter's rco reads 0. Decode the last address from the counter Q==15 via the fimC net of the fluxo de dados (rco gated with ent=1 upstream), as already wired at top level.
- proximo: ent=enp=1 (counter +1 at the edge leaving proximo), timer cleared; -> espera.
- Fim states: pronto=1 plus the matching flag.
  - fim_acertou: acertou=1.
  - fim_errou: errou=1.
  - fim_timeout: errou=1, timeout=1.
  - iniciar=1 -> preparacao, else stay.
- Latencies:
  - jogada to verdict: 3 edges (espera->registra->comparacao->fim).
  - jogada to counter increment: 4 edges.
- Wrap-around: the counter never wraps under this block's control; the verdict is declared at address 15.
- Unused codes 0011, 0111, 1000, 1001, 1011, 1100, 1111 -> inicial on the next edge.
- iniciar asserted in non-fim/non-inicial states is ignored.

Decomposition:
- Shared package/include holds:
  - the 4-bit state code localparams;
  - the output-flag polarity constants (CLR_ATIVO=0, LD_ATIVO=0).
- One natural sub-module: timer_timeout.
  - Ports: clock, reset, zera, conta, fim.
  - Width is $clog2(TIMEOUT_CICLOS).
  - The FSM drives zera in preparacao/proximo and conta in espera.

Test Plan:
- Bench instantiates contador_163, fed by clr_n/ld_n/ent/enp/carga_valor. fimC comes from Q==15 and igual from a behavioural memory.
- Reset mid-espera (address 5): state 0000 immediately, before the clock edge; all outputs default; then iniciar -> counter Q=0 after preparacao.
- 16 correct jogadas, ENDERECO_INICIAL=0 -> Q steps 0..15, no increment after 15; pronto=acertou=1, db_estado=1010.
- Mismatch at address 3 (igual=0) -> fim_errou 3 edges after jogada, errou=1, timeout=0, Q stays 3.
- TIMEOUT_CICLOS=8, no jogada -> fim_timeout exactly 8 edges after entering espera; errou=timeout=1.
- jogada in the same cycle timer hits 7 -> registra taken, no timeout; timer restarts after proximo.
- ENDERECO_INICIAL=4'd12, 4 correct moves -> acertou after Q=15; then iniciar in fim_acertou reloads 12 and restarts.
